// File: rtl/png_score_counter.sv
// png_score_counter: one player's score, BCD units plus a tens bit, 0..MAX_SCORE.
// Counts falling edges of the active-low miss pulse and flags game over at the selected limit.
//
// Ports:
//   clk          rising-edge system clock
//   _rst         synchronous active-low reset, wins over everything
//   _score_in    active-low score pulse, asynchronous to clk
//   _clr_score   synchronous active-low score clear (game start / attract)
//   limit_sel    0: GAME_LIMIT_LO, 1: GAME_LIMIT_HI
//   units        BCD units digit 0..9
//   tens         tens digit 0/1
//   game_over    high while score >= selected limit
//   score_strobe one-cycle pulse per accepted increment
module png_score_counter #(
    parameter int unsigned GAME_LIMIT_LO = 11,
    parameter int unsigned GAME_LIMIT_HI = 15,
    parameter int unsigned MAX_SCORE     = 19
) (
    input  logic       clk,
    input  logic       _rst,
    input  logic       _score_in,
    input  logic       _clr_score,
    input  logic       limit_sel,
    output logic [3:0] units,
    output logic       tens,
    output logic       game_over,
    output logic       score_strobe
);

    localparam logic [4:0] LIM_LO = 5'(GAME_LIMIT_LO);
    localparam logic [4:0] LIM_HI = 5'(GAME_LIMIT_HI);
    localparam logic [4:0] MAX5   = 5'(MAX_SCORE);

    logic       s1;
    logic       s2;
    logic       s3;
    // Shifts in ones after reset so that s3 only qualifies an edge once
    // it holds a real sample; a pulse still low at reset release is ignored.
    logic [2:0] warm;
    logic       fall;

    logic [4:0] score;
    logic [4:0] score_nxt;
    logic [4:0] limit;
    logic [3:0] units_nxt;
    logic       tens_nxt;
    logic       inc;

    assign fall  = s3 & ~s2 & warm[2];
    assign score = {1'b0, units} + (tens ? 5'd10 : 5'd0);
    assign limit = limit_sel ? LIM_HI : LIM_LO;

    always_comb begin
        units_nxt = units;
        tens_nxt  = tens;
        // A blocked edge is simply dropped, never queued.
        inc       = fall & ~game_over & (score < MAX5);
        if (inc) begin
            if (units == 4'd9) begin
                units_nxt = 4'd0;
                tens_nxt  = 1'b1;
            end else begin
                units_nxt = units + 4'd1;
            end
        end
        score_nxt = {1'b0, units_nxt} + (tens_nxt ? 5'd10 : 5'd0);
    end

    always_ff @(posedge clk) begin
        if (!_rst) begin
            s1           <= 1'b1;
            s2           <= 1'b1;
            s3           <= 1'b1;
            warm         <= 3'b000;
            units        <= 4'd0;
            tens         <= 1'b0;
            game_over    <= 1'b0;
            score_strobe <= 1'b0;
        end else begin
            // The synchroniser keeps running through a clear, so an edge
            // that lands during the clear is consumed and lost.
            s1   <= _score_in;
            s2   <= s1;
            s3   <= s2;
            warm <= {warm[1:0], 1'b1};
            if (!_clr_score) begin
                units        <= 4'd0;
                tens         <= 1'b0;
                game_over    <= 1'b0;
                score_strobe <= 1'b0;
            end else begin
                units        <= units_nxt;
                tens         <= tens_nxt;
                // Follows limit_sel every cycle; not sticky.
                game_over    <= (score_nxt >= limit);
                score_strobe <= inc;
            end
        end
    end

endmodule
